// File: rtl/onewire_rom_layer_if.sv
// Bus bundle between the 1-Wire ROM layer, the bit/byte IO controller and the
// memory-function layer. The ROM layer drives through "master"; the peers see "slave".
interface onewire_rom_layer_if;
  logic       nBusRst;
  logic       nODBusRst;
  logic       ioTrig;
  logic       nRxTx;
  logic       ioBitMode;
  logic [7:0] sentDat;
  logic [7:0] receiveDat;
  logic       ioDone;
  logic       odMode;
  logic       funTrig;
  logic       funDone;
  logic [7:0] romCmd;
  logic       idle;

  modport master (
    input  nBusRst, nODBusRst, receiveDat, ioDone, funDone,
    output ioTrig, nRxTx, ioBitMode, sentDat, odMode, funTrig, romCmd, idle
  );
  modport slave (
    output nBusRst, nODBusRst, receiveDat, ioDone, funDone,
    input  ioTrig, nRxTx, ioBitMode, sentDat, odMode, funTrig, romCmd, idle
  );
endinterface

// File: rtl/onewire_rom_layer.sv
// 1-Wire ROM-function layer: READ/MATCH/SKIP/SEARCH/RESUME ROM, then hands off to the
// memory-function layer. Define OVERDRIVE_EN to add OD SKIP (3Ch) and OD MATCH (69h).
module onewire_rom_layer #(
  parameter logic [63:0] ROM_ID     = 64'h8C00_0000_1234_562D,
  parameter logic [7:0]  CMD_READ   = 8'h33,
  parameter logic [7:0]  CMD_MATCH  = 8'h55,
  parameter logic [7:0]  CMD_SKIP   = 8'hCC,
  parameter logic [7:0]  CMD_SEARCH = 8'hF0,
  parameter logic [7:0]  CMD_RESUME = 8'hA5
) (
  input logic               clk,
  input logic               Rst,
  onewire_rom_layer_if.master bus
);
  typedef enum logic [2:0] {S_WAIT_RST, S_GET_CMD, S_READ_ROM, S_MATCH_ROM, S_SEARCH, S_FUN} state_t;

  state_t     r_state, w_state;
  logic       r_busy, w_busy;            // an IO transfer is outstanding
  logic       r_fun_started, w_fun_started;
  logic [2:0] r_byte, w_byte;
  logic [5:0] r_bit, w_bit;
  logic [1:0] r_phase, w_phase;          // search: 0 tx id bit, 1 tx complement, 2 rx master bit
  logic       r_rc, w_rc;
  logic       r_od, w_od;
  logic [7:0] r_cmd, w_cmd;
  logic       r_io_trig, w_io_trig;
  logic       r_nrxtx, w_nrxtx;
  logic       r_bitmode, w_bitmode;
  logic [7:0] r_sent, w_sent;
  logic       r_fun_trig, w_fun_trig;
  logic [7:0] w_rom_byte;

  assign w_rom_byte = ROM_ID[{r_byte, 3'b000} +: 8];

  always_comb begin
    w_state       = r_state;
    w_busy        = r_busy;
    w_fun_started = r_fun_started;
    w_byte        = r_byte;
    w_bit         = r_bit;
    w_phase       = r_phase;
    w_rc          = r_rc;
    w_od          = r_od;
    w_cmd         = r_cmd;
    w_io_trig     = 1'b0;
    w_nrxtx       = r_nrxtx;
    w_bitmode     = r_bitmode;
    w_sent        = r_sent;
    w_fun_trig    = 1'b0;
    // A bus reset overrides whatever handshake lands in the same cycle.
    if (!bus.nBusRst || !bus.nODBusRst) begin
      w_state       = S_GET_CMD;
      w_busy        = 1'b0;
      w_fun_started = 1'b0;
      w_byte        = 3'd0;
      w_bit         = 6'd0;
      w_phase       = 2'd0;
      if (!bus.nBusRst) w_od = 1'b0;
    end else begin
      case (r_state)
        S_GET_CMD: begin
          if (!r_busy) begin
            w_io_trig = 1'b1; w_busy = 1'b1; w_nrxtx = 1'b0; w_bitmode = 1'b0;
          end else if (bus.ioDone) begin
            w_busy = 1'b0;
            w_cmd  = bus.receiveDat;
            case (bus.receiveDat)
              CMD_READ:   begin w_state = S_READ_ROM; w_rc = 1'b0; end
              CMD_SKIP:   begin w_state = S_FUN;      w_rc = 1'b0; end
              CMD_MATCH:  w_state = S_MATCH_ROM;
              CMD_SEARCH: w_state = S_SEARCH;
              CMD_RESUME: w_state = r_rc ? S_FUN : S_WAIT_RST;
`ifdef OVERDRIVE_EN
              8'h3C:      begin w_state = S_FUN; w_od = 1'b1; w_rc = 1'b0; end
              8'h69:      begin w_state = S_MATCH_ROM; w_od = 1'b1; end
`endif
              default:    begin w_state = S_WAIT_RST; w_rc = 1'b0; end
            endcase
          end
        end
        S_READ_ROM: begin
          if (!r_busy) begin
            w_io_trig = 1'b1; w_busy = 1'b1; w_nrxtx = 1'b1; w_bitmode = 1'b0;
            w_sent    = w_rom_byte;
          end else if (bus.ioDone) begin
            w_busy = 1'b0;
            if (r_byte == 3'd7) w_state = S_FUN;
            else                w_byte  = r_byte + 3'd1;
          end
        end
        S_MATCH_ROM: begin
          if (!r_busy) begin
            w_io_trig = 1'b1; w_busy = 1'b1; w_nrxtx = 1'b0; w_bitmode = 1'b0;
          end else if (bus.ioDone) begin
            w_busy = 1'b0;
            if (bus.receiveDat != w_rom_byte) begin
              w_state = S_WAIT_RST;
`ifdef OVERDRIVE_EN
              if (r_cmd == 8'h69) w_od = 1'b0;
`endif
            end else if (r_byte == 3'd7) begin
              w_state = S_FUN; w_rc = 1'b1;
            end else begin
              w_byte = r_byte + 3'd1;
            end
          end
        end
        S_SEARCH: begin
          if (!r_busy) begin
            w_io_trig = 1'b1; w_busy = 1'b1; w_bitmode = 1'b1;
            w_nrxtx   = (r_phase != 2'd2);
            if (r_phase == 2'd0)      w_sent = {7'd0, ROM_ID[r_bit]};
            else if (r_phase == 2'd1) w_sent = {7'd0, ~ROM_ID[r_bit]};
          end else if (bus.ioDone) begin
            w_busy = 1'b0;
            if (r_phase != 2'd2) begin
              w_phase = r_phase + 2'd1;
            end else if (bus.receiveDat[0] != ROM_ID[r_bit]) begin
              w_state = S_WAIT_RST;
            end else if (r_bit == 6'd63) begin
              w_state = S_FUN; w_rc = 1'b1;
            end else begin
              w_bit = r_bit + 6'd1; w_phase = 2'd0;
            end
          end
        end
        S_FUN: begin
          if (!r_fun_started) begin
            w_fun_trig = 1'b1; w_fun_started = 1'b1;
          end else if (bus.funDone) begin
            w_state = S_WAIT_RST; w_fun_started = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_WAIT_RST;
      r_busy        <= 1'b0;
      r_fun_started <= 1'b0;
      r_byte        <= 3'd0;
      r_bit         <= 6'd0;
      r_phase       <= 2'd0;
      r_rc          <= 1'b0;
      r_od          <= 1'b0;
      r_cmd         <= 8'd0;
      r_io_trig     <= 1'b0;
      r_nrxtx       <= 1'b0;
      r_bitmode     <= 1'b0;
      r_sent        <= 8'd0;
      r_fun_trig    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_busy        <= w_busy;
      r_fun_started <= w_fun_started;
      r_byte        <= w_byte;
      r_bit         <= w_bit;
      r_phase       <= w_phase;
      r_rc          <= w_rc;
      r_od          <= w_od;
      r_cmd         <= w_cmd;
      r_io_trig     <= w_io_trig;
      r_nrxtx       <= w_nrxtx;
      r_bitmode     <= w_bitmode;
      r_sent        <= w_sent;
      r_fun_trig    <= w_fun_trig;
    end
  end

  assign bus.ioTrig    = r_io_trig;
  assign bus.nRxTx     = r_nrxtx;
  assign bus.ioBitMode = r_bitmode;
  assign bus.sentDat   = r_sent;
  assign bus.funTrig   = r_fun_trig;
  assign bus.romCmd    = r_cmd;
  assign bus.idle      = (r_state == S_WAIT_RST);
`ifdef OVERDRIVE_EN
  assign bus.odMode    = r_od;
`else
  assign bus.odMode    = 1'b0;
`endif
endmodule
